traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Passive checker for the traffic light controller's lamp outputs. It observes `red`, `yellow` and `green` every clock, tracks the expected phase sequence RED → GREEN → YELLOW → RED, and checks each phase's dwell time against its programmed duration. It raises a sticky fault with a cause code on the first violation and counts completed good cycles. It sits beside the controller on the same clock and consumes its three lamp outputs.

## Interface
- `RED_TIME`, 30: required cycles with red asserted per phase.
- `GRN_TIME`, 30: required cycles with green asserted per phase.
- `YEL_TIME`, 5: required cycles with yellow asserted per phase.
- `CNT_W`, 6: dwell counter width. All `*_TIME` values are in 1 .. 2^CNT_W−1.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `red_in`  in  1  observed red lamp.
- `yel_in`  in  1  observed yellow lamp.
- `green_in`  in  1  observed green lamp.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  3  cause of the first fault: 0 none, 1 illegal lamp encoding, 2 wrong sequence, 3 early change, 4 overstay.
- `phase`  out  2  tracked phase: 0 SYNC, 1 RED, 2 GREEN, 3 YELLOW. Reads 0 in FAULT.
- `cycles_ok`  out  16  count of completed valid RED→GREEN→YELLOW→RED cycles; saturates at 0xFFFF.

## Operation
- Lamp vector `L = {red_in, yel_in, green_in}`. A legal vector is exactly one-hot.
- States: SYNC, RED, GREEN, YELLOW, FAULT. Dwell counter `dwell` is CNT_W bits.
- SYNC: entered on reset.
  - On `L == 100`, go to RED with `dwell = 1`.
  - Any other `L`, including illegal vectors, keeps the block in SYNC with no fault.
- Phase state P (RED/GREEN/YELLOW), with duration T(P) and successor N(P). Per sample, rules are evaluated in this priority order:
  1. `L` not one-hot → FAULT, code 1.
  2. `L` equals P's lamp:
     - If `dwell == T(P)`, → FAULT, code 4 (overstay: the (T+1)th sample).
     - Otherwise `dwell` increments.
  3. `L` is a lamp other than P's or N(P)'s → FAULT, code 2.
  4. `L` is N(P)'s lamp:
     - If `dwell < T(P)`, → FAULT, code 3.
     - If `dwell == T(P)`, move to N(P) with `dwell = 1`. When the move is YELLOW→RED, `cycles_ok` increments (saturating).
- FAULT: absorbing until `reset`.
  - `fault = 1`. `fault_code` holds the first cause. `cycles_ok` is frozen. `dwell` is don't-care.
- No width surprises:
  - `dwell` never exceeds T(P), so it cannot wrap.
  - `cycles_ok` holds at 0xFFFF and does not wrap to 0.

## Timing
- All outputs are registered directly from state/registers. No combinational path from the lamp inputs to the outputs.
- Latency is one cycle. A sample present before rising edge k is reflected in the outputs after edge k:
  - `phase` change,
  - `fault` assertion,
  - `cycles_ok` increment.
- Reset values: `fault = 0`, `fault_code = 0`, `phase = 0`, `cycles_ok = 0`, state SYNC, `dwell = 0`.
- Reset has priority over everything on the same edge, including a simultaneous fault condition.
- Reset mid-phase discards progress. The next phase is only accepted after a fresh red-only sample in SYNC.
- A controller and monitor released from reset on the same edge: the controller's first red cycle is counted as `dwell = 1`. A conforming controller therefore produces exactly T samples per phase.
- Edge case T = 1: the lamp must change on every sample. A second consecutive sample of the same lamp is an overstay.

## Test plan
- Nominal: reset 2 cycles, then drive 3 ideal cycles (red 30, green 30, yellow 5), then red → `fault = 0`, `cycles_ok = 3`, `phase` sequence 1→2→3→1 with each change one cycle after the input change.
- Overstay: ideal red 30, then green held 31 samples → `fault = 1`, `fault_code = 4` after the edge of the 31st green sample, `phase = 0`; later legal stimulus leaves `fault`, `fault_code` and `cycles_ok` unchanged.
- Early change: red 30, green 30, yellow 4, then red → `fault_code = 3` after the first red sample; `cycles_ok` stays 0.
- Illegal encoding: in RED at `dwell = 10`, drive `L = 110` for one cycle → `fault_code = 1`. Repeat after reset with `L = 000` during GREEN → `fault_code = 1`.
- Wrong sequence: red 30, then yellow → `fault_code = 2`.
- Sync and reset: reset asserted during GREEN → all outputs 0 next cycle. Stimulus resumes mid-green and yellow (including an illegal 011) → `phase = 0`, `fault = 0`. First red-only sample → `phase = 1`, and a following ideal cycle yields `cycles_ok = 1`.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker of a traffic light controller's lamp
// outputs. Tracks RED -> GREEN -> YELLOW -> RED, checks each phase's dwell
// against its programmed duration, latches the first fault cause and counts
// completed good cycles.
module traffic_light_monitor #(
  parameter int unsigned RED_TIME = 30,
  parameter int unsigned GRN_TIME = 30,
  parameter int unsigned YEL_TIME = 5,
  parameter int unsigned CNT_W    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        red_in,
  input  logic        yel_in,
  input  logic        green_in,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [1:0]  phase,
  output logic [15:0] cycles_ok
);

  typedef enum logic [2:0] {
    S_SYNC   = 3'd0,
    S_RED    = 3'd1,
    S_GREEN  = 3'd2,
    S_YELLOW = 3'd3,
    S_FAULT  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RED_T = CNT_W'(RED_TIME);
  localparam logic [CNT_W-1:0] GRN_T = CNT_W'(GRN_TIME);
  localparam logic [CNT_W-1:0] YEL_T = CNT_W'(YEL_TIME);

  // Lamp vector {red, yellow, green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [2:0] C_NONE    = 3'd0;
  localparam logic [2:0] C_ILLEGAL = 3'd1;
  localparam logic [2:0] C_SEQ     = 3'd2;
  localparam logic [2:0] C_EARLY   = 3'd3;
  localparam logic [2:0] C_OVER    = 3'd4;

  localparam logic [15:0] CYC_MAX = 16'hFFFF;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic [1:0]       phase_q, phase_d;
  logic [15:0]      cycles_q, cycles_d;

  logic [2:0]       lamp;
  logic             one_hot;
  logic [2:0]       cur_lamp;
  logic [2:0]       nxt_lamp;
  logic [CNT_W-1:0] cur_t;
  state_e           nxt_state;

  assign lamp    = {red_in, yel_in, green_in};
  assign one_hot = (lamp == LAMP_RED) || (lamp == LAMP_YEL) || (lamp == LAMP_GRN);

  // Next-state: phase tracking, dwell checking, fault capture, cycle counting
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    code_d    = code_q;
    cycles_d  = cycles_q;
    fault_d   = fault_q;
    phase_d   = 2'd0;
    cur_lamp  = 3'b000;
    nxt_lamp  = 3'b000;
    cur_t     = '0;
    nxt_state = S_FAULT;

    case (state_q)
      S_RED:    begin cur_lamp = LAMP_RED; nxt_lamp = LAMP_GRN; cur_t = RED_T; nxt_state = S_GREEN;  end
      S_GREEN:  begin cur_lamp = LAMP_GRN; nxt_lamp = LAMP_YEL; cur_t = GRN_T; nxt_state = S_YELLOW; end
      S_YELLOW: begin cur_lamp = LAMP_YEL; nxt_lamp = LAMP_RED; cur_t = YEL_T; nxt_state = S_RED;    end
      default:  ;
    endcase

    case (state_q)
      S_SYNC: begin
        if (lamp == LAMP_RED) begin
          state_d = S_RED;
          dwell_d = CNT_W'(1);
        end
      end
      S_RED, S_GREEN, S_YELLOW: begin
        if (!one_hot) begin
          state_d = S_FAULT;
          code_d  = C_ILLEGAL;
        end else if (lamp == cur_lamp) begin
          if (dwell_q == cur_t) begin
            state_d = S_FAULT;
            code_d  = C_OVER;
          end else begin
            dwell_d = dwell_q + CNT_W'(1);
          end
        end else if (lamp != nxt_lamp) begin
          state_d = S_FAULT;
          code_d  = C_SEQ;
        end else if (dwell_q < cur_t) begin
          state_d = S_FAULT;
          code_d  = C_EARLY;
        end else begin
          state_d = nxt_state;
          dwell_d = CNT_W'(1);
          if ((state_q == S_YELLOW) && (cycles_q != CYC_MAX)) begin
            cycles_d = cycles_q + 16'd1;
          end
        end
      end
      default: ;
    endcase

    fault_d = (state_d == S_FAULT);
    case (state_d)
      S_RED:    phase_d = 2'd1;
      S_GREEN:  phase_d = 2'd2;
      S_YELLOW: phase_d = 2'd3;
      default:  phase_d = 2'd0;
    endcase
  end

  // State and output registers, synchronous reset has priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_SYNC;
      dwell_q  <= '0;
      fault_q  <= 1'b0;
      code_q   <= C_NONE;
      phase_q  <= 2'd0;
      cycles_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      phase_q  <= phase_d;
      cycles_q <= cycles_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign phase      = phase_q;
  assign cycles_ok  = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor: directed scenarios plus randomized
// near-ideal controller traffic, checked every cycle against a reference
// model. Two instances: default timing (30/30/5) and the all-ones edge case.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic clk = 1'b0;
  logic reset, red_in, yel_in, green_in;

  logic        f0, f1;
  logic [2:0]  c0, c1;
  logic [1:0]  p0, p1;
  logic [15:0] n0, n1;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance: phase 0 sync, 1 red, 2 green, 3 yellow
  int tm[2][4];
  int mp[2], md[2], mc[2], mcode[2];

  always #5 clk = ~clk;

  traffic_light_monitor u_dut0 (
    .clk(clk), .reset(reset), .red_in(red_in), .yel_in(yel_in), .green_in(green_in),
    .fault(f0), .fault_code(c0), .phase(p0), .cycles_ok(n0)
  );

  traffic_light_monitor #(.RED_TIME(1), .GRN_TIME(1), .YEL_TIME(1), .CNT_W(6)) u_dut1 (
    .clk(clk), .reset(reset), .red_in(red_in), .yel_in(yel_in), .green_in(green_in),
    .fault(f1), .fault_code(c1), .phase(p1), .cycles_ok(n1)
  );

  function automatic int lamp_phase(input logic [2:0] l);
    case (l)
      3'b100:  return 1;
      3'b001:  return 2;
      3'b010:  return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model(input int i, input logic [2:0] l, input logic rst);
    int q;
    q = lamp_phase(l);
    if (rst) begin
      mp[i] = 0; md[i] = 0; mc[i] = 0; mcode[i] = 0;
    end else if (mcode[i] != 0) begin
      // absorbing fault
    end else if (mp[i] == 0) begin
      if (l == R) begin mp[i] = 1; md[i] = 1; end
    end else if (q == 0) begin
      mcode[i] = 1;
    end else if (q == mp[i]) begin
      if (md[i] == tm[i][mp[i]]) mcode[i] = 4;
      else md[i]++;
    end else if (q != (mp[i] % 3) + 1) begin
      mcode[i] = 2;
    end else if (md[i] < tm[i][mp[i]]) begin
      mcode[i] = 3;
    end else begin
      if (mp[i] == 3 && mc[i] < 65535) mc[i]++;
      mp[i] = q;
      md[i] = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int ef, ep;
      ef = (mcode[i] != 0) ? 1 : 0;
      ep = (mcode[i] != 0) ? 0 : mp[i];
      check($sformatf("u%0d.fault", i),      32'(i ? f1 : f0), 32'(ef));
      check($sformatf("u%0d.fault_code", i), 32'(i ? c1 : c0), 32'(mcode[i]));
      check($sformatf("u%0d.phase", i),      32'(i ? p1 : p0), 32'(ep));
      check($sformatf("u%0d.cycles_ok", i),  32'(i ? n1 : n0), 32'(mc[i]));
    end
  endtask

  // One sample: drive, clock, advance model, check #1 after the edge
  task automatic step(input logic [2:0] l, input logic rst);
    {red_in, yel_in, green_in} = l;
    reset = rst;
    @(posedge clk);
    model(0, l, rst);
    model(1, l, rst);
    #1;
    check_all();
  endtask

  task automatic run(input logic [2:0] l, input int n);
    repeat (n) step(l, 1'b0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(3'b000, 1'b1);
  endtask

  // One controller cycle with occasional dwell perturbations and glitches
  task automatic rand_cycle();
    for (int p = 1; p <= 3; p++) begin
      logic [2:0] l;
      int dur, r;
      l   = (p == 1) ? R : (p == 2) ? G : Y;
      dur = tm[0][p];
      r   = int'($urandom_range(0, 19));
      if (r == 0) dur = dur - 1;
      if (r == 1) dur = dur + 1;
      run(l, dur);
      if ($urandom_range(0, 29) == 0) step(3'($urandom_range(0, 7)), 1'b0);
      if ($urandom_range(0, 39) == 0) step(l, 1'b1);
    end
  endtask

  initial begin
    tm[0][0] = 0; tm[0][1] = 30; tm[0][2] = 30; tm[0][3] = 5;
    tm[1][0] = 0; tm[1][1] = 1;  tm[1][2] = 1;  tm[1][3] = 1;
    for (int i = 0; i < 2; i++) begin mp[i] = 0; md[i] = 0; mc[i] = 0; mcode[i] = 0; end
    reset = 1'b1; {red_in, yel_in, green_in} = 3'b000;
    #2;

    // Nominal: three ideal cycles then red
    do_reset(2);
    check("rst.fault", 32'(f0), 0);
    check("rst.phase", 32'(p0), 0);
    for (int k = 0; k < 3; k++) begin run(R, 30); run(G, 30); run(Y, 5); end
    step(R, 1'b0);
    check("nom.cycles", 32'(n0), 3);
    check("nom.fault",  32'(f0), 0);
    check("nom.phase",  32'(p0), 1);

    // Overstay on green, then legal traffic must not disturb the fault
    do_reset(1);
    run(R, 30); run(G, 31);
    check("ovr.code",  32'(c0), 4);
    check("ovr.phase", 32'(p0), 0);
    run(Y, 5); run(R, 30);
    check("ovr.hold", 32'(c0), 4);

    // Early change out of yellow
    do_reset(1);
    run(R, 30); run(G, 30); run(Y, 4); step(R, 1'b0);
    check("early.code",   32'(c0), 3);
    check("early.cycles", 32'(n0), 0);

    // Illegal encodings
    do_reset(1);
    run(R, 10); step(3'b110, 1'b0);
    check("ill110.code", 32'(c0), 1);
    do_reset(1);
    run(R, 30); run(G, 7); step(3'b000, 1'b0);
    check("ill000.code", 32'(c0), 1);

    // Wrong sequence: red straight to yellow
    do_reset(1);
    run(R, 30); step(Y, 1'b0);
    check("seq.code", 32'(c0), 2);

    // Reset mid-green, resync on the next red-only sample
    do_reset(1);
    run(R, 30); run(G, 12);
    step(G, 1'b1);
    check("rmid.phase", 32'(p0), 0);
    run(G, 10); run(Y, 2); step(3'b011, 1'b0); run(Y, 3);
    check("sync.phase", 32'(p0), 0);
    check("sync.fault", 32'(f0), 0);
    step(R, 1'b0);
    check("sync.red", 32'(p0), 1);
    run(R, 29); run(G, 30); run(Y, 5); step(R, 1'b0);
    check("sync.cycles", 32'(n0), 1);

    // T = 1 edge case on the second instance
    do_reset(1);
    for (int k = 0; k < 2; k++) begin step(R, 1'b0); step(G, 1'b0); step(Y, 1'b0); end
    step(R, 1'b0);
    check("t1.cycles", 32'(n1), 2);
    step(R, 1'b0);
    check("t1.over", 32'(c1), 4);

    // Randomized near-ideal traffic with junk before sync
    for (int t = 0; t < 8; t++) begin
      do_reset(1);
      repeat ($urandom_range(0, 4)) step(3'($urandom_range(0, 7)), 1'b0);
      for (int k = 0; k < 6; k++) rand_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
